msg_byte_tx: RTL and testbench
==============================

MSG_BYTE_TX -- requirements
Module: msg_byte_tx

Interface
REQ-001 The block SHALL have parameter MSG_BITS, default 32, the message width in bits; it is a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 sends byte [MSG_BITS-1:MSG_BITS-8] first, 0 sends byte [7:0] first.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 msg_i  input  MSG_BITS  message word to serialize.
REQ-007 msg_valid_i  input  1  msg_i is valid.
REQ-008 msg_ready_o  output  1  block accepts msg_i this cycle.
REQ-009 byte_o  output  8  current outgoing byte.
REQ-010 byte_valid_o  output  1  byte_o is valid.
REQ-011 byte_ready_i  input  1  downstream accepts byte_o this cycle.
REQ-012 byte_last_o  output  1  byte_o is the final byte of the current message.
REQ-013 busy_o  output  1  a message is held and not yet fully sent.

Function
REQ-014 The block SHALL define NBYTES = MSG_BITS/8 and a byte counter of width max(1, clog2(NBYTES)).
REQ-015 The block SHALL implement FSM states IDLE and SEND.
REQ-016 In IDLE, the block SHALL drive msg_ready_o=1, byte_valid_o=0, byte_last_o=0 and busy_o=0.
REQ-017 A message SHALL be accepted on a rising edge with msg_valid_i=1 and msg_ready_o=1: msg_i is loaded into a holding/shift register, the counter is cleared, and the FSM goes to SEND.
REQ-018 byte_valid_o SHALL assert the cycle after acceptance (latency 1 from accept to first byte valid).
REQ-019 In SEND, byte_valid_o=1 and busy_o=1 SHALL hold continuously until the last byte transfers.
REQ-020 A byte transfer SHALL occur on a rising edge with byte_valid_o=1 and byte_ready_i=1; each transfer increments the counter and advances to the next byte in the MSB_FIRST order.
REQ-021 While byte_valid_o=1 and byte_ready_i=0, byte_o and byte_last_o SHALL remain stable.
REQ-022 byte_last_o SHALL be 1 exactly when counter = NBYTES-1 in SEND; for MSG_BITS=8 it is 1 on the only byte.
REQ-023 On the transfer of the last byte with no new message accepted, the FSM SHALL return to IDLE.
REQ-024 In SEND, msg_ready_o SHALL be byte_last_o AND byte_ready_i (combinational), giving back-to-back messages with no bubble.
REQ-025 When a new message is accepted in the same cycle as the last-byte transfer, the FSM SHALL stay in SEND, load the new word, clear the counter, and present its first byte next cycle.
REQ-026 msg_ready_o SHALL NOT depend on msg_valid_i.
REQ-027 msg_i and msg_valid_i SHALL be ignored whenever msg_ready_o=0; there is no internal queue beyond one message.
REQ-028 byte_o SHALL be 8'h00 whenever byte_valid_o=0.
REQ-029 The counter SHALL never exceed NBYTES-1; no wrap occurs within a message.

Reset
REQ-030 rst_n_i=0 SHALL asynchronously force IDLE, counter 0, holding register 0, byte_valid_o=0, byte_last_o=0, busy_o=0, byte_o=8'h00.
REQ-031 msg_ready_o SHALL be 0 while rst_n_i=0 and 1 from the first clock after deassertion.
REQ-032 Reset asserted mid-message SHALL discard the message; no remaining bytes are emitted after release.

Verification
REQ-033 Basic MSB-first send: MSG_BITS=32, MSB_FIRST=1, byte_ready_i=1, msg_i=32'hA1B2C3D4 accepted at cycle 0 -> byte_o A1,B2,C3,D4 on cycles 1-4, byte_last_o only with D4, IDLE at cycle 5.
REQ-034 LSB-first send: MSB_FIRST=0, msg 32'hA1B2C3D4 -> byte order D4,C3,B2,A1.
REQ-035 Backpressure: byte_ready_i=0 for 3 cycles while byte_o=B2 -> B2 and byte_last_o=0 held stable, msg_ready_o=0, no byte skipped or repeated.
REQ-036 Back-to-back: 32'h11223344 then 32'h55667788 with msg_valid_i held high -> second message accepted on the 44 transfer edge, byte_o 11,22,33,44,55,66,77,88 on 8 consecutive cycles.
REQ-037 Reset mid-operation: rst_n_i=0 after byte B2 transfers -> outputs cleared immediately, no C3/D4 after release, msg_ready_o=1 one clock after release.
REQ-038 Single-byte config: MSG_BITS=8, msg 8'h5A -> one byte 5A with byte_last_o=1, back to IDLE next cycle.

Source files
------------

// File: rtl/msg_byte_tx.sv
// Message-to-byte serializer: accepts a MSG_BITS word and emits it as a
// ready/valid byte stream in MSB- or LSB-first order, with last-byte marking.
module msg_byte_tx #(
  parameter int MSG_BITS  = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [MSG_BITS-1:0] msg_i,
  input  logic                msg_valid_i,
  output logic                msg_ready_o,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  input  logic                byte_ready_i,
  output logic                byte_last_o,
  output logic                busy_o
);

  localparam int NBYTES = MSG_BITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [MSG_BITS-1:0] r_shift;
  logic [MSG_BITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_rst_done;
  logic                w_ready;
  logic                w_valid;
  logic                w_last;
  logic                w_busy;
  logic [7:0]          w_head;
  logic [MSG_BITS-1:0] w_shifted;

  // The outgoing byte always sits at the head end of the shift register.
  always_comb begin
    if (MSB_FIRST) begin
      w_head    = r_shift[MSG_BITS-1 -: 8];
      w_shifted = r_shift << 8;
    end else begin
      w_head    = r_shift[7:0];
      w_shifted = r_shift >> 8;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low until the first clock after reset release.
        w_ready = r_rst_done;
        if (msg_valid_i && w_ready) begin
          w_state_nxt = S_SEND;
          w_shift_nxt = msg_i;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        w_last  = (r_cnt == LAST_CNT);
        w_ready = w_last & byte_ready_i;
        if (byte_ready_i) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (msg_valid_i) begin
              w_shift_nxt = msg_i;
            end else begin
              w_state_nxt = S_IDLE;
              w_shift_nxt = '0;
            end
          end else begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rst_done <= 1'b1;
    end
  end

  assign msg_ready_o  = w_ready;
  assign byte_valid_o = w_valid;
  assign byte_last_o  = w_last;
  assign busy_o       = w_busy;
  assign byte_o       = w_valid ? w_head : 8'h00;

endmodule

// File: tb/tb_msg_byte_tx.sv
// Scoreboard bench for msg_byte_tx: 32-bit MSB-first and LSB-first instances
// share one stimulus stream; an 8-bit instance runs its own single-byte cases.
module tb_msg_byte_tx;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] msg;
  logic        msg_valid;
  logic        byte_ready;
  logic [7:0]  msg8;
  logic        msg8_valid;
  logic        b8_ready;

  logic       m_ready, m_valid, m_last, m_busy;
  logic [7:0] m_byte;
  logic       l_ready, l_valid, l_last, l_busy;
  logic [7:0] l_byte;
  logic       b_ready, b_valid, b_last, b_busy;
  logic [7:0] b_byte;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t q_b[$];

  int checks   = 0;
  int failures = 0;

  msg_byte_tx #(.MSG_BITS(32), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg), .msg_valid_i(msg_valid),
    .msg_ready_o(m_ready), .byte_o(m_byte), .byte_valid_o(m_valid),
    .byte_ready_i(byte_ready), .byte_last_o(m_last), .busy_o(m_busy));

  msg_byte_tx #(.MSG_BITS(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg), .msg_valid_i(msg_valid),
    .msg_ready_o(l_ready), .byte_o(l_byte), .byte_valid_o(l_valid),
    .byte_ready_i(byte_ready), .byte_last_o(l_last), .busy_o(l_busy));

  msg_byte_tx #(.MSG_BITS(8), .MSB_FIRST(1'b1)) u_b8 (
    .clk_i(clk), .rst_n_i(rst_n), .msg_i(msg8), .msg_valid_i(msg8_valid),
    .msg_ready_o(b_ready), .byte_o(b_byte), .byte_valid_o(b_valid),
    .byte_ready_i(b8_ready), .byte_last_o(b_last), .busy_o(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      q_m.push_back('{b: d[31-8*i -: 8], last: (i == 3)});
      q_l.push_back('{b: d[8*i +: 8],    last: (i == 3)});
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", 32'(m_busy), 32'd0);
  endtask

  // Monitor: a transfer is committed at the next rising edge when valid&ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m_valid && byte_ready) begin
        if (q_m.size() == 0) chk("msb_unexpected_byte", 32'(m_byte), 32'hFFFF_FFFF);
        else begin
          e = q_m.pop_front();
          chk("msb_byte", 32'(m_byte), 32'(e.b));
          chk("msb_last", 32'(m_last), 32'(e.last));
        end
      end
      if (l_valid && byte_ready) begin
        if (q_l.size() == 0) chk("lsb_unexpected_byte", 32'(l_byte), 32'hFFFF_FFFF);
        else begin
          e = q_l.pop_front();
          chk("lsb_byte", 32'(l_byte), 32'(e.b));
          chk("lsb_last", 32'(l_last), 32'(e.last));
        end
      end
      if (b_valid && b8_ready) begin
        if (q_b.size() == 0) chk("b8_unexpected_byte", 32'(b_byte), 32'hFFFF_FFFF);
        else begin
          e = q_b.pop_front();
          chk("b8_byte", 32'(b_byte), 32'(e.b));
          chk("b8_last", 32'(b_last), 32'(e.last));
        end
      end
      if (!m_valid) chk("msb_idle_byte_zero", 32'(m_byte), 32'd0);
      if (!l_valid) chk("lsb_idle_byte_zero", 32'(l_byte), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    msg        = '0;
    msg_valid  = 1'b0;
    byte_ready = 1'b0;
    msg8       = '0;
    msg8_valid = 1'b0;
    b8_ready   = 1'b0;

    // Reset state
    #2;
    chk("rst_ready",  32'(m_ready), 32'd0);
    chk("rst_valid",  32'(m_valid), 32'd0);
    chk("rst_byte",   32'(m_byte),  32'd0);
    chk("rst_busy",   32'(m_busy),  32'd0);
    chk("rst_last",   32'(m_last),  32'd0);
    chk("rst_b8_rdy", 32'(b_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("rel_ready_before_clk", 32'(m_ready), 32'd0);
    step();
    chk("rel_ready_after_clk", 32'(m_ready), 32'd1);
    chk("rel_b8_ready", 32'(b_ready), 32'd1);

    // Basic send, both byte orders
    byte_ready = 1'b1;
    msg        = 32'hA1B2C3D4;
    msg_valid  = 1'b1;
    push32(msg);
    step();
    msg_valid = 1'b0;
    chk("basic_c1_valid", 32'(m_valid), 32'd1);
    chk("basic_c1_byte",  32'(m_byte),  32'hA1);
    chk("basic_c1_lsb",   32'(l_byte),  32'hD4);
    chk("basic_c1_last",  32'(m_last),  32'd0);
    step();
    step();
    step();
    chk("basic_c4_byte", 32'(m_byte), 32'hD4);
    chk("basic_c4_last", 32'(m_last), 32'd1);
    chk("basic_c4_lsb",  32'(l_byte), 32'hA1);
    step();
    chk("basic_c5_valid", 32'(m_valid), 32'd0);
    chk("basic_c5_busy",  32'(m_busy),  32'd0);
    chk("basic_c5_ready", 32'(m_ready), 32'd1);

    // Backpressure while B2 is presented; an offered word must be ignored
    msg       = 32'hA1B2C3D4;
    msg_valid = 1'b1;
    push32(msg);
    step();
    msg_valid = 1'b0;
    step();
    chk("bp_pre_byte", 32'(m_byte), 32'hB2);
    byte_ready = 1'b0;
    msg        = 32'hDEADBEEF;
    msg_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_byte",  32'(m_byte),  32'hB2);
      chk("bp_hold_last",  32'(m_last),  32'd0);
      chk("bp_hold_ready", 32'(m_ready), 32'd0);
      chk("bp_hold_lsb",   32'(l_byte),  32'hC3);
    end
    msg_valid  = 1'b0;
    byte_ready = 1'b1;
    wait_idle();

    // Back-to-back messages, no bubble
    msg       = 32'h11223344;
    msg_valid = 1'b1;
    push32(msg);
    step();
    msg = 32'h55667788;
    push32(msg);
    for (int i = 1; i <= 8; i++) begin
      chk("b2b_valid", 32'(m_valid), 32'd1);
      if (i == 4) chk("b2b_ready_on_last", 32'(m_ready), 32'd1);
      if (i == 5) msg_valid = 1'b0;
      step();
    end
    chk("b2b_idle", 32'(m_busy), 32'd0);

    // Reset mid-message after B2 transfers
    msg       = 32'hA1B2C3D4;
    msg_valid = 1'b1;
    push32(msg);
    step();
    msg_valid = 1'b0;
    step();
    step();
    chk("mid_pre_byte", 32'(m_byte), 32'hC3);
    rst_n = 1'b0;
    q_m.delete();
    q_l.delete();
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_byte",  32'(m_byte),  32'd0);
    chk("mid_rst_busy",  32'(m_busy),  32'd0);
    chk("mid_rst_ready", 32'(m_ready), 32'd0);
    step();
    rst_n = 1'b1;
    chk("mid_rel_ready_before_clk", 32'(m_ready), 32'd0);
    step();
    chk("mid_rel_ready", 32'(m_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_resume", 32'(m_valid), 32'd0);
      step();
    end

    // Single-byte configuration
    b8_ready   = 1'b1;
    msg8       = 8'h5A;
    msg8_valid = 1'b1;
    q_b.push_back('{b: 8'h5A, last: 1'b1});
    step();
    msg8_valid = 1'b0;
    chk("b8_c1_valid", 32'(b_valid), 32'd1);
    chk("b8_c1_byte",  32'(b_byte),  32'h5A);
    chk("b8_c1_last",  32'(b_last),  32'd1);
    step();
    chk("b8_c2_valid", 32'(b_valid), 32'd0);
    chk("b8_c2_ready", 32'(b_ready), 32'd1);
    msg8       = 8'h5A;
    msg8_valid = 1'b1;
    q_b.push_back('{b: 8'h5A, last: 1'b1});
    step();
    msg8 = 8'hC3;
    q_b.push_back('{b: 8'hC3, last: 1'b1});
    step();
    msg8_valid = 1'b0;
    chk("b8_b2b_byte", 32'(b_byte), 32'hC3);
    step();
    chk("b8_b2b_idle", 32'(b_busy), 32'd0);

    step();
    chk("q_msb_empty", 32'(q_m.size()), 32'd0);
    chk("q_lsb_empty", 32'(q_l.size()), 32'd0);
    chk("q_b8_empty",  32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
